// File: rtl/imem_load_arbiter.sv
// Instruction-memory port arbiter: muxes the CPU fetch address with a byte-serial loader
// that packs little-endian words and writes them. Define IMEM_LOAD_CHECKSUM_EN for load_csum.
module imem_load_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [4:0]  load_words,
  input  logic        load_abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] cpu_pc,
  output logic        cpu_stall,
  output logic [31:0] mem_add,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic        busy,
  output logic        load_done,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic [7:0]  load_csum,
`endif
  output logic        load_err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t             state;
  state_t             nxt;
  logic [CNT_W-1:0]   word_idx;
  logic [CNT_W-1:0]   word_cnt;
  logic [1:0]         byte_idx;
  logic [31:0]        asm_word;
  logic [ADDR_W-1:0]  wr_off;
  logic               take;
  logic               last_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  function automatic logic [CNT_W-1:0] clamp_words(input logic [4:0] w);
    if (int'(w) > MAX_WORDS) return CNT_W'(MAX_WORDS);
    else                     return CNT_W'(w);
  endfunction

  assign take      = byte_valid & byte_ready;
  assign last_word = (word_idx + CNT_W'(1)) == word_cnt;
  assign wr_off    = ADDR_W'({word_idx, 2'b00});

  // The CPU owns the address bus only while idle; the loader address is zero-extended.
  assign mem_add   = (state == IDLE) ? cpu_pc : {{(32-ADDR_W){1'b0}}, wr_off};
  assign mem_wdata = asm_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign load_csum = csum;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (load_start) nxt = (load_words == 5'd0) ? DONE : COLLECT;
      COLLECT: begin
        // Abort beats a simultaneous lane-3 byte: the word is never written.
        if (load_abort)                       nxt = DONE;
        else if (take && byte_idx == 2'd3)    nxt = WRITE;
      end
      WRITE:   nxt = (load_abort || last_word) ? DONE : COLLECT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_idx   <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      load_err   <= 1'b0;
      byte_ready <= 1'b0;
      cpu_stall  <= 1'b0;
      busy       <= 1'b0;
      mem_wen    <= 1'b0;
      load_done  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= nxt;
      byte_ready <= (nxt == COLLECT);
      cpu_stall  <= (nxt != IDLE);
      busy       <= (nxt != IDLE);
      mem_wen    <= (nxt == WRITE);
      load_done  <= (nxt == DONE);
      case (state)
        IDLE: begin
          if (load_start) begin
            word_idx <= '0;
            byte_idx <= '0;
            word_cnt <= clamp_words(load_words);
            load_err <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        COLLECT: begin
          if (load_abort) begin
            load_err <= 1'b1;
          end else if (take) begin
            asm_word[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= csum + byte_data;
`endif
          end
        end
        WRITE: begin
          word_idx <= word_idx + CNT_W'(1);
          byte_idx <= '0;
          if (load_abort) load_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed self-checking bench for imem_load_arbiter: single word, full and clamped
// sessions, empty session, aborts, ignored requests and reset during a write.
module tb_imem_load_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [4:0]  load_words = '0;
  logic        load_abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic [31:0] cpu_pc = 32'h0000_1234;
  logic        cpu_stall;
  logic [31:0] mem_add;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        busy;
  logic        load_done;
  logic        load_err;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  load_csum;
`endif

  imem_load_arbiter #(.ADDR_W(6), .MAX_WORDS(16)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_words(load_words),
    .load_abort(load_abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .mem_add(mem_add),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .busy(busy), .load_done(load_done),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .load_csum(load_csum),
`endif
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int stall_bad = 0;
  logic [31:0] wr_add [32];
  logic [31:0] wr_data [32];

  // Passive record of every write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wen === 1'b1) begin
        if (wr_cnt < 32) begin
          wr_add[wr_cnt]  = mem_add;
          wr_data[wr_cnt] = mem_wdata;
        end
        wr_cnt++;
      end
      if (load_done === 1'b1) done_cnt++;
      if (cpu_stall !== busy) stall_bad++;
    end
  end

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; stall_bad = 0;
  endtask

  task automatic start(input logic [4:0] w);
    @(negedge clk);
    load_start = 1'b1; load_words = w;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1; byte_data = b;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    vec++;
    if (n >= 20) begin errs++; $display("FAIL send_byte timeout: byte_ready=%b required 1", byte_ready); end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk); n++;
    end
    vec++;
    if (busy !== 1'b0) begin errs++; $display("FAIL wait_idle timeout: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
    vec++; if (byte_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", byte_ready); end
    vec++; if (mem_wen !== 1'b0) begin errs++; $display("FAIL rst_wen: got %b want 0", mem_wen); end
    vec++; if (load_done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", load_done); end
    vec++; if (load_err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", load_err); end
    vec++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    vec++; if (mem_add !== 32'h1234) begin errs++; $display("FAIL rst_add: got %h want 00001234", mem_add); end
    reset = 1'b0;
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_word();
    clear_log();
    start(5'd1);
    vec++; if (byte_ready !== 1'b1) begin errs++; $display("FAIL sw_ready: got %b want 1", byte_ready); end
    vec++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL sw_stall: got %b want 1", cpu_stall); end
    vec++; if (mem_add !== 32'h0) begin errs++; $display("FAIL sw_add_collect: got %h want 0", mem_add); end
    send_byte(8'h13); send_byte(8'h00); send_byte(8'hA0); send_byte(8'hE3);
    vec++; if (mem_wen !== 1'b1) begin errs++; $display("FAIL sw_wen: got %b want 1", mem_wen); end
    vec++; if (mem_wdata !== 32'hE3A0_0013) begin errs++; $display("FAIL sw_wdata: got %h want e3a00013", mem_wdata); end
    vec++; if (byte_ready !== 1'b0) begin errs++; $display("FAIL sw_ready_wr: got %b want 0", byte_ready); end
    @(negedge clk);
    vec++; if (load_done !== 1'b1) begin errs++; $display("FAIL sw_done: got %b want 1", load_done); end
    vec++; if (mem_wen !== 1'b0) begin errs++; $display("FAIL sw_wen_done: got %b want 0", mem_wen); end
    @(negedge clk);
    vec++; if (load_done !== 1'b0) begin errs++; $display("FAIL sw_done_pulse: got %b want 0", load_done); end
    vec++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL sw_stall_idle: got %b want 0", cpu_stall); end
    vec++; if (mem_add !== 32'h1234) begin errs++; $display("FAIL sw_add_idle: got %h want 00001234", mem_add); end
    vec++; if (wr_cnt !== 1) begin errs++; $display("FAIL sw_wr_cnt: got %0d want 1", wr_cnt); end
    vec++; if (wr_add[0] !== 32'h0) begin errs++; $display("FAIL sw_wr_add: got %h want 0", wr_add[0]); end
  endtask

  task automatic test_idle_bytes_ignored();
    clear_log();
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    vec++; if (mem_wdata !== 32'hE3A0_0013) begin errs++; $display("FAIL idle_byte_wdata: got %h want e3a00013", mem_wdata); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_byte_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_load(input logic [4:0] w);
    clear_log();
    start(w);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    vec++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL full_stall_mid: got %b want 1", cpu_stall); end
    wait_idle();
    vec++; if (wr_cnt !== 16) begin errs++; $display("FAIL full_wr_cnt(w=%0d): got %0d want 16", w, wr_cnt); end
    vec++; if (done_cnt !== 1) begin errs++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    vec++; if (stall_bad !== 0) begin errs++; $display("FAIL full_stall_busy: got %0d want 0", stall_bad); end
    vec++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL full_stall_idle: got %b want 0", cpu_stall); end
    for (int k = 0; k < 16; k++) begin
      vec++;
      if (wr_add[k] !== 32'(4*k)) begin errs++; $display("FAIL full_add[%0d]: got %h want %h", k, wr_add[k], 32'(4*k)); end
      vec++;
      if (wr_data[k] !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) begin
        errs++; $display("FAIL full_data[%0d]: got %h want %h", k, wr_data[k], {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      end
    end
  endtask

  task automatic test_zero_words();
    clear_log();
    start(5'd0);
    vec++; if (load_done !== 1'b1) begin errs++; $display("FAIL zero_done: got %b want 1", load_done); end
    vec++; if (byte_ready !== 1'b0) begin errs++; $display("FAIL zero_ready: got %b want 0", byte_ready); end
    vec++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL zero_stall: got %b want 1", cpu_stall); end
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL zero_busy: got %b want 0", busy); end
    vec++; if (wr_cnt !== 0) begin errs++; $display("FAIL zero_wr_cnt: got %0d want 0", wr_cnt); end
  endtask

  task automatic test_abort();
    clear_log();
    start(5'd4);
    for (int i = 0; i < 14; i++) send_byte(8'hC0 + 8'(i));
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    vec++; if (load_done !== 1'b1) begin errs++; $display("FAIL abort_done: got %b want 1", load_done); end
    vec++; if (load_err !== 1'b1) begin errs++; $display("FAIL abort_err: got %b want 1", load_err); end
    vec++; if (mem_wen !== 1'b0) begin errs++; $display("FAIL abort_wen: got %b want 0", mem_wen); end
    wait_idle();
    vec++; if (wr_cnt !== 3) begin errs++; $display("FAIL abort_wr_cnt: got %0d want 3", wr_cnt); end
    vec++; if (wr_add[2] !== 32'h8) begin errs++; $display("FAIL abort_last_add: got %h want 8", wr_add[2]); end
    vec++; if (load_err !== 1'b1) begin errs++; $display("FAIL abort_err_sticky: got %b want 1", load_err); end
  endtask

  task automatic test_abort_vs_lane3();
    clear_log();
    start(5'd1);
    vec++; if (load_err !== 1'b0) begin errs++; $display("FAIL err_cleared: got %b want 0", load_err); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    byte_valid = 1'b1; byte_data = 8'h77; load_abort = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; load_abort = 1'b0;
    vec++; if (mem_wen !== 1'b0) begin errs++; $display("FAIL race_wen: got %b want 0", mem_wen); end
    vec++; if (load_done !== 1'b1) begin errs++; $display("FAIL race_done: got %b want 1", load_done); end
    vec++; if (load_err !== 1'b1) begin errs++; $display("FAIL race_err: got %b want 1", load_err); end
    wait_idle();
    vec++; if (wr_cnt !== 0) begin errs++; $display("FAIL race_wr_cnt: got %0d want 0", wr_cnt); end
  endtask

  task automatic test_start_ignored();
    clear_log();
    start(5'd2);
    send_byte(8'h10); send_byte(8'h11);
    start(5'd5);
    for (int i = 2; i < 8; i++) send_byte(8'h10 + 8'(i));
    wait_idle();
    vec++; if (wr_cnt !== 2) begin errs++; $display("FAIL ign_wr_cnt: got %0d want 2", wr_cnt); end
    vec++; if (wr_add[1] !== 32'h4) begin errs++; $display("FAIL ign_add1: got %h want 4", wr_add[1]); end
    vec++; if (wr_data[0] !== 32'h1312_1110) begin errs++; $display("FAIL ign_data0: got %h want 13121110", wr_data[0]); end
    vec++; if (done_cnt !== 1) begin errs++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_in_write();
    clear_log();
    start(5'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    vec++; if (mem_wen !== 1'b1) begin errs++; $display("FAIL rw_wen_before: got %b want 1", mem_wen); end
    cpu_pc = 32'h20;
    reset = 1'b1;
    #1;
    vec++; if (mem_wen !== 1'b0) begin errs++; $display("FAIL rw_wen: got %b want 0", mem_wen); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rw_busy: got %b want 0", busy); end
    vec++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL rw_stall: got %b want 0", cpu_stall); end
    vec++; if (mem_add !== 32'h20) begin errs++; $display("FAIL rw_add: got %h want 00000020", mem_add); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rw_idle_after: got %b want 0", busy); end
    vec++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rw_wdata_clr: got %h want 0", mem_wdata); end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    start(5'd1);
    send_byte(8'hFF); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    vec++; if (load_csum !== 8'h01) begin errs++; $display("FAIL csum: got %h want 01", load_csum); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_idle_bytes_ignored();
    test_full_load(5'd16);
    test_full_load(5'd20);
    test_zero_words();
    test_abort();
    test_abort_vs_lane3();
    test_start_ignored();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_in_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
